// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: load-use and mult/div stalls, youngest-first operand
// forwarding select, a mult/div busy tracker and a saturating stall counter.

module fwdStageMatch (
    input  logic [4:0] wa,
    input  logic       we,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    output logic       hitA,
    output logic       hitB
);
    // Register 0 is hardwired zero, so it is never forwarded.
    assign hitA = we && (wa == rsE) && (rsE != 5'd0);
    assign hitB = we && (wa == rtE) && (rtE != 5'd0);
endmodule

module hazard_scoreboard #(
    parameter int NUM_FWD    = 2,
    parameter int MD_LATENCY = 8,
    parameter int SW         = $clog2(NUM_FWD + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [4:0]           rs_d,
    input  logic [4:0]           rt_d,
    input  logic                 use_rs_d,
    input  logic                 use_rt_d,
    input  logic                 md_start_d,
    input  logic                 hilo_rd_d,
    input  logic [4:0]           wa_e,
    input  logic                 reg_write_e,
    input  logic                 mem_to_reg_e,
    input  logic [4:0]           rs_e,
    input  logic [4:0]           rt_e,
    input  logic [5*NUM_FWD-1:0] wa_fwd,
    input  logic [NUM_FWD-1:0]   reg_write_fwd,
    output logic [SW-1:0]        fwd_a_sel,
    output logic [SW-1:0]        fwd_b_sel,
    output logic                 stall_d,
    output logic                 flush_e,
    output logic                 md_busy,
    output logic                 md_done,
    output logic [31:0]          stall_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [7:0]         cnt;
    logic [31:0]        stallCnt;
    logic               loadUse, mdHold, stall, mdAccept;
    logic [NUM_FWD-1:0] hitA, hitB;

    assign loadUse = mem_to_reg_e && reg_write_e && (wa_e != 5'd0) &&
                     ((use_rs_d && (rs_d == wa_e)) || (use_rt_d && (rt_d == wa_e)));
    assign mdHold   = md_busy && (md_start_d || hilo_rd_d);
    assign stall    = loadUse || mdHold;
    assign stall_d  = stall;
    assign flush_e  = stall;
    assign mdAccept = md_start_d && !stall;

    for (genvar k = 0; k < NUM_FWD; k++) begin : gStage
        fwdStageMatch uMatch (
            .wa  (wa_fwd[5*k +: 5]),
            .we  (reg_write_fwd[k]),
            .rsE (rs_e),
            .rtE (rt_e),
            .hitA(hitA[k]),
            .hitB(hitB[k])
        );
    end

    // Scan oldest to youngest so the youngest matching stage overrides.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (hitA[k]) fwd_a_sel = SW'(k + 1);
            if (hitB[k]) fwd_b_sel = SW'(k + 1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (mdAccept) begin
                        state <= BUSY;
                        cnt   <= 8'(MD_LATENCY - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                    else             state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign md_busy = (state == BUSY);
    assign md_done = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           stallCnt <= 32'd0;
        else if (stall && (stallCnt != '1))     stallCnt <= stallCnt + 32'd1;
    end

    assign stall_count = stallCnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench: a driver pushes model expectations per cycle,
// a monitor pops and compares them against the DUT outputs.

module tb_hazard_scoreboard;
    localparam int NF = 2;
    localparam int L  = 8;
    localparam int SW = $clog2(NF + 1);

    typedef struct {
        logic [4:0]          rsD, rtD, waE, rsE, rtE;
        logic                useRs, useRt, mdStart, hiloRd, regWriteE, memToRegE;
        logic [NF-1:0][4:0]  waFwd;
        logic [NF-1:0]       regWriteFwd;
    } stim_t;

    typedef struct {
        logic          stall, busy, done;
        logic [SW-1:0] fwdA, fwdB;
        logic [31:0]   stallCount;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic [4:0] rs_d, rt_d, wa_e, rs_e, rt_e;
    logic use_rs_d, use_rt_d, md_start_d, hilo_rd_d, reg_write_e, mem_to_reg_e;
    logic [5*NF-1:0] wa_fwd;
    logic [NF-1:0]   reg_write_fwd;
    logic [SW-1:0]   fwd_a_sel, fwd_b_sel;
    logic stall_d, flush_e, md_busy, md_done;
    logic [31:0] stall_count;

    int nChecks = 0;
    int nErr    = 0;
    exp_t expQ[$];

    // Model state: cycle index, cycle in which the last start was accepted,
    // and the number of stalled cycles seen so far (saturating).
    int          cyc      = 0;
    int          startAcc = -100;
    logic [31:0] stallModel = 32'd0;

    hazard_scoreboard #(.NUM_FWD(NF), .MD_LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
        .md_start_d(md_start_d), .hilo_rd_d(hilo_rd_d),
        .wa_e(wa_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
        .rs_e(rs_e), .rt_e(rt_e), .wa_fwd(wa_fwd), .reg_write_fwd(reg_write_fwd),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_d(stall_d), .flush_e(flush_e), .md_busy(md_busy), .md_done(md_done),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        nChecks++;
        if (act !== expv) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rsD = 0; s.rtD = 0; s.waE = 0; s.rsE = 0; s.rtE = 0;
        s.useRs = 0; s.useRt = 0; s.mdStart = 0; s.hiloRd = 0;
        s.regWriteE = 0; s.memToRegE = 0; s.waFwd = '0; s.regWriteFwd = '0;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.rsD = 5'($urandom_range(0, 3)); s.rtD = 5'($urandom_range(0, 3));
        s.waE = 5'($urandom_range(0, 3)); s.rsE = 5'($urandom_range(0, 3));
        s.rtE = 5'($urandom_range(0, 3));
        s.useRs = 1'($urandom); s.useRt = 1'($urandom);
        s.mdStart = ($urandom_range(0, 5) == 0);
        s.hiloRd  = ($urandom_range(0, 3) == 0);
        s.regWriteE = 1'($urandom); s.memToRegE = ($urandom_range(0, 2) == 0);
        for (int k = 0; k < NF; k++) s.waFwd[k] = 5'($urandom_range(0, 3));
        s.regWriteFwd = NF'($urandom);
        return s;
    endfunction

    function automatic logic [SW-1:0] youngest(stim_t s, logic [4:0] src);
        for (int k = 0; k < NF; k++)
            if (s.regWriteFwd[k] && s.waFwd[k] == src && src != 0) return SW'(k + 1);
        return '0;
    endfunction

    task automatic step(input stim_t s, input bit preload = 1'b0);
        exp_t e;
        logic lu;
        @(negedge clk);
        reset_n = 1'b1;
        if (preload) begin
            force dut.stallCnt = 32'hFFFF_FFFD;
            release dut.stallCnt;
            stallModel = 32'hFFFF_FFFD;
        end
        rs_d = s.rsD; rt_d = s.rtD; use_rs_d = s.useRs; use_rt_d = s.useRt;
        md_start_d = s.mdStart; hilo_rd_d = s.hiloRd;
        wa_e = s.waE; reg_write_e = s.regWriteE; mem_to_reg_e = s.memToRegE;
        rs_e = s.rsE; rt_e = s.rtE; wa_fwd = s.waFwd; reg_write_fwd = s.regWriteFwd;

        e.busy = (cyc > startAcc) && (cyc <= startAcc + L);
        e.done = (cyc == startAcc + L + 1);
        lu = s.memToRegE && s.regWriteE && s.waE != 0 &&
             ((s.useRs && s.rsD == s.waE) || (s.useRt && s.rtD == s.waE));
        e.stall = lu || (e.busy && (s.mdStart || s.hiloRd));
        e.fwdA = youngest(s, s.rsE);
        e.fwdB = youngest(s, s.rtE);
        e.stallCount = stallModel;
        e.cyc = cyc;
        expQ.push_back(e);

        if (s.mdStart && !e.stall) startAcc = cyc;
        if (e.stall && stallModel != 32'hFFFF_FFFF) stallModel = stallModel + 32'd1;
        cyc++;
    endtask

    // Asynchronous reset mid-cycle with a stale start present on the input.
    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        md_start_d = 1'b1;
        #1;
        chk("async_rst_busy", 32'(md_busy), 32'd0);
        chk("async_rst_done", 32'(md_done), 32'd0);
        chk("async_rst_stallcnt", stall_count, 32'd0);
        startAcc = -100;
        stallModel = 32'd0;
        cyc++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk($sformatf("stall_d@%0d", e.cyc), 32'(stall_d), 32'(e.stall));
                chk($sformatf("flush_e@%0d", e.cyc), 32'(flush_e), 32'(e.stall));
                chk($sformatf("md_busy@%0d", e.cyc), 32'(md_busy), 32'(e.busy));
                chk($sformatf("md_done@%0d", e.cyc), 32'(md_done), 32'(e.done));
                chk($sformatf("fwd_a@%0d", e.cyc), 32'(fwd_a_sel), 32'(e.fwdA));
                chk($sformatf("fwd_b@%0d", e.cyc), 32'(fwd_b_sel), 32'(e.fwdB));
                chk($sformatf("stall_count@%0d", e.cyc), stall_count, e.stallCount);
            end
        end
    end

    initial begin : driver
        stim_t s;
        reset_n = 1'b1;
        {rs_d, rt_d, wa_e, rs_e, rt_e} = '0;
        {use_rs_d, use_rt_d, md_start_d, hilo_rd_d, reg_write_e, mem_to_reg_e} = '0;
        wa_fwd = '0; reg_write_fwd = '0;
        #1 reset_n = 1'b0;
        #1;
        chk("reset_busy", 32'(md_busy), 32'd0);
        chk("reset_done", 32'(md_done), 32'd0);
        chk("reset_stallcnt", stall_count, 32'd0);

        // Load-use stall then release.
        s = idle();
        s.waE = 5; s.memToRegE = 1; s.regWriteE = 1; s.rsD = 5; s.useRs = 1;
        step(s);
        s.memToRegE = 0;
        step(s);

        // Forwarding priority and register 0.
        s = idle();
        s.waFwd[0] = 7; s.waFwd[1] = 7; s.regWriteFwd = 2'b11; s.rsE = 7; s.rtE = 7;
        step(s);
        s.regWriteFwd = 2'b10;
        step(s);
        s.rsE = 0; s.waFwd[0] = 0; s.regWriteFwd = 2'b11;
        step(s);

        // Mult/div latency, hilo read while busy and in the done cycle.
        s = idle(); s.mdStart = 1;
        step(s);
        for (int t = 1; t <= 10; t++) begin
            s = idle();
            if (t == 4 || t == 9) s.hiloRd = 1;
            step(s);
        end

        // Start coincident with load-use, retried when hazard clears.
        s = idle();
        s.waE = 3; s.memToRegE = 1; s.regWriteE = 1; s.rtD = 3; s.useRt = 1; s.mdStart = 1;
        step(s);
        s.memToRegE = 0;
        step(s);
        for (int t = 0; t < 10; t++) step(idle());

        // Reset in the middle of an operation.
        s = idle(); s.mdStart = 1;
        step(s);
        step(idle());
        step(idle());
        doReset();
        for (int t = 0; t < 12; t++) step(idle());

        // Saturation of the stall counter.
        s = idle();
        s.waE = 9; s.memToRegE = 1; s.regWriteE = 1; s.rsD = 9; s.useRs = 1;
        step(s, 1'b1);
        step(s);
        step(s);
        step(idle());
        step(idle());
        doReset();

        for (int t = 0; t < 400; t++) step(randStim());
        for (int t = 0; t < 12; t++) step(idle());

        repeat (3) @(negedge clk);
        #4;
        if (expQ.size() != 0) begin
            nChecks++; nErr++;
            $display("FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end
endmodule
